sum4b_seq_ctrl: RTL and testbench

Sequencer that performs a wide (4*NIBBLES-bit) unsigned addition by time-multiplexing one shared sum4b 4-bit adder (ports A, B, Sum, Cout; no carry-in). The controller drives the adder operands nibble by nibble, least-significant nibble first. Because sum4b has no carry-in, an incoming carry is added in a second adder pass (an increment). The adder is instantiated beside this block at the parent level. Its A/B inputs are driven from add_a/add_b, and its Sum/Cout outputs are returned on add_sum/add_cout.

---
 rtl/sum4b_seq_ctrl_if.sv | 28 ++
 rtl/sum4b_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_sum4b_seq_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sum4b_seq_ctrl_if.sv
// Bundle between the wide-add sequencer, its requester and the shared sum4b adder.
interface sum4b_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic [3:0]   add_sum;
  logic         add_cout;

  modport master (
    output start, A, B, add_sum, add_cout,
    input  busy, done, Sum, Cout, add_a, add_b
  );

  modport slave (
    input  start, A, B, add_sum, add_cout,
    output busy, done, Sum, Cout, add_a, add_b
  );
endinterface

// File: rtl/sum4b_seq_ctrl.sv
// Wide unsigned adder sequencer: walks nibbles LSB first through one shared
// carry-less 4-bit adder, spending a second pass (increment) on any carried-in nibble.
module sum4b_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic             clk,
  input logic             rst,
  sum4b_seq_ctrl_if.slave bus
);
  localparam int W = 4 * NIBBLES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] opa_q, opa_d;
  logic [W-1:0] opb_q, opb_d;
  logic [W-1:0] sum_q, sum_d;
  logic [2:0]   idx_q, idx_d;
  logic         carry_q, carry_d;
  logic         c1_q, c1_d;
  logic         cout_q, cout_d;
  logic [3:0]   tmp_q, tmp_d;
  logic         last_s;

  function automatic logic [3:0] get_nib(input logic [W-1:0] x, input logic [2:0] i);
    logic [3:0] r;
    r = 4'h0;
    for (int n = 0; n < NIBBLES; n++) begin
      r = (i == 3'(n)) ? x[4*n +: 4] : r;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] put_nib(input logic [W-1:0] s, input logic [2:0] i,
                                           input logic [3:0] v);
    logic [W-1:0] r;
    r = s;
    for (int n = 0; n < NIBBLES; n++) begin
      r[4*n +: 4] = (i == 3'(n)) ? v : s[4*n +: 4];
    end
    return r;
  endfunction

  assign last_s   = (idx_q == 3'(NIBBLES - 1));
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;

  // Next-state and adder-operand decode.
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    c1_d      = c1_q;
    cout_d    = cout_q;
    tmp_d     = tmp_q;
    bus.add_a = 4'h0;
    bus.add_b = 4'h0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d   = bus.A;
          opb_d   = bus.B;
          idx_d   = 3'd0;
          carry_d = 1'b0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        bus.busy  = 1'b1;
        bus.add_a = get_nib(opa_q, idx_q);
        bus.add_b = get_nib(opb_q, idx_q);
        if (carry_q) begin
          // Carried-in nibble: park the raw sum and finish it with +1 in INC.
          tmp_d   = bus.add_sum;
          c1_d    = bus.add_cout;
          state_d = INC;
        end else begin
          sum_d   = put_nib(sum_q, idx_q, bus.add_sum);
          carry_d = bus.add_cout;
          if (last_s) begin
            cout_d  = bus.add_cout;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ADD;
          end
        end
      end
      INC: begin
        bus.busy  = 1'b1;
        bus.add_a = tmp_q;
        bus.add_b = 4'b0001;
        sum_d     = put_nib(sum_q, idx_q, bus.add_sum);
        carry_d   = c1_q | bus.add_cout;
        if (last_s) begin
          cout_d  = c1_q | bus.add_cout;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ADD;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      idx_q   <= 3'd0;
      carry_q <= 1'b0;
      c1_q    <= 1'b0;
      cout_q  <= 1'b0;
      tmp_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c1_q    <= c1_d;
      cout_q  <= cout_d;
      tmp_q   <= tmp_d;
    end
  end
endmodule

// File: tb/tb_sum4b_seq_ctrl.sv
// Bench for sum4b_seq_ctrl: 16-bit and 4-bit builds, each beside a behavioural sum4b,
// checked against an arithmetic model of result, latency and increment passes.
module tb_sum4b_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  sum4b_seq_ctrl_if #(.NIBBLES(4)) b4 ();
  sum4b_seq_ctrl_if #(.NIBBLES(1)) b1 ();

  assign {b4.add_cout, b4.add_sum} = {1'b0, b4.add_a} + {1'b0, b4.add_b};
  assign {b1.add_cout, b1.add_sum} = {1'b0, b1.add_a} + {1'b0, b1.add_b};

  sum4b_seq_ctrl #(.NIBBLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
  sum4b_seq_ctrl #(.NIBBLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Nibbles (above the LSB one) whose incoming carry is 1.
  function automatic int model_k(input longint unsigned a, input longint unsigned b, input int n);
    int k;
    longint unsigned m;
    k = 0;
    for (int i = 1; i < n; i++) begin
      m = 64'd1 << (4 * i);
      if ((a % m) + (b % m) >= m) k++;
    end
    return k;
  endfunction

  task automatic run4(input logic [15:0] a, input logic [15:0] b, input bit noise,
                      input bit start_in_done, input bit lit, input logic [16:0] lit_res,
                      input int lit_lat);
    logic [16:0] exp_res;
    int exp_lat, exp_ones, cyc, busy_cyc, ones_cyc;
    logic [15:0] bv;
    exp_res  = {1'b0, a} + {1'b0, b};
    exp_lat  = 4 + model_k(a, b, 4);
    exp_ones = exp_lat - 4;
    bv       = b;
    for (int i = 0; i < 4; i++) if (bv[4*i +: 4] == 4'h1) exp_ones++;
    b4.A = a; b4.B = b; b4.start = 1'b1;
    step();
    b4.start = 1'b0; b4.A = 16'($urandom); b4.B = 16'($urandom);
    cyc = 0; busy_cyc = 0; ones_cyc = 0;
    while (b4.done !== 1'b1 && cyc < 40) begin
      if (b4.busy === 1'b1) busy_cyc++;
      if (b4.busy === 1'b1 && b4.add_b === 4'h1) ones_cyc++;
      if (noise && cyc == 1) begin
        b4.start = 1'b1; b4.A = 16'hFFFF; b4.B = 16'hFFFF;
      end else begin
        b4.start = 1'b0;
      end
      step();
      cyc++;
    end
    chk("latency", cyc, exp_lat);
    chk("busy_cycles", busy_cyc, exp_lat);
    chk("add_b_one_cycles", ones_cyc, exp_ones);
    chk("result", {b4.Cout, b4.Sum}, exp_res);
    chk("busy_in_done", b4.busy, 0);
    if (lit) begin
      chk("lit_result", {b4.Cout, b4.Sum}, lit_res);
      chk("lit_latency", cyc, lit_lat);
    end
    if (start_in_done) begin
      b4.start = 1'b1; b4.A = 16'hFFFF; b4.B = 16'hFFFF;
    end
    step();
    b4.start = 1'b0;
    chk("done_single_pulse", b4.done, 0);
    chk("idle_after_done", b4.busy, 0);
    chk("result_hold", {b4.Cout, b4.Sum}, exp_res);
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b);
    int cyc;
    b1.A = a; b1.B = b; b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    cyc = 0;
    while (b1.done !== 1'b1 && cyc < 10) begin
      step();
      cyc++;
    end
    chk("n1_result", {b1.Cout, b1.Sum}, {1'b0, a} + {1'b0, b});
    chk("n1_latency", cyc, 1 + model_k(a, b, 1));
    step();
  endtask

  initial begin
    int seen;
    logic [15:0] ra, rb;
    rst = 1'b1;
    b4.start = 1'b0; b4.A = 16'h0; b4.B = 16'h0;
    b1.start = 1'b0; b1.A = 4'h0; b1.B = 4'h0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", b4.busy, 0);
    chk("rst_done", b4.done, 0);
    chk("rst_sum", {b4.Cout, b4.Sum}, 0);
    chk("rst_add_ab", {b4.add_a, b4.add_b}, 0);
    chk("rst_n1_sum", {b1.Cout, b1.Sum}, 0);

    run4(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 17'h05555, 4);
    run4(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 17'h00100, 6);
    run4(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 17'h10000, 7);
    run4(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 17'h1FFFE, 7);
    run4(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, 17'h05555, 4);
    run4(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b1, 17'h05555, 4);
    run4(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 17'h00003, 4);

    // Reset in the middle of an operation discards it.
    b4.A = 16'hFFFF; b4.B = 16'h0001; b4.start = 1'b1;
    step();
    b4.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", b4.busy, 0);
    chk("midrst_done", b4.done, 0);
    chk("midrst_sum", {b4.Cout, b4.Sum}, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (b4.done === 1'b1 || b4.busy === 1'b1) seen++;
      step();
    end
    chk("midrst_quiet", seen, 0);
    run4(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 17'h10000, 7);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(3) == 0) ? 16'(~ra + 16'($urandom_range(2))) : 16'($urandom);
      run4(ra, rb, 1'b0, 1'b0, 1'b0, 17'h0, 0);
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run1(4'(a), 4'(b));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
